// File: rtl/fc_port_state_machine.sv
// rtl/fc_port_state_machine.sv - FC port state machine selecting the TX ordered set from recognised RX primitive sequences
// Optional link statistics and lr_req input are built when FC_PORT_STATS_EN is defined.
module fc_port_state_machine #(
   parameter int RECOG_COUNT    = 3,
   parameter int LOS_CYCLES     = 1024,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx_valid,
   input  logic [4:0]  rx_prim,
   input  logic        rx_sync,
   input  logic        offline_req,
`ifdef FC_PORT_STATS_EN
   input  logic        lr_req,
   output logic [15:0] link_fail_count,
   output logic [15:0] lr_count,
`endif
   output logic [3:0]  state,
   output logic [4:0]  tx_prim,
   output logic        link_active
);

   typedef enum logic [3:0] {
      ST_AC  = 4'd0,
      ST_LR1 = 4'd1,
      ST_LR2 = 4'd2,
      ST_LR3 = 4'd3,
      ST_LF1 = 4'd4,
      ST_LF2 = 4'd5,
      ST_OL1 = 4'd6,
      ST_OL2 = 4'd7,
      ST_OL3 = 4'd8
   } state_t;

   localparam logic [4:0] P_IDLE = 5'd0;
   localparam logic [4:0] P_NOS  = 5'd14;
   localparam logic [4:0] P_OLS  = 5'd15;
   localparam logic [4:0] P_LR   = 5'd16;
   localparam logic [4:0] P_LRR  = 5'd17;

   localparam int LOS_W = $clog2(LOS_CYCLES) + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [2:0]       RECOG_MAX = 3'(RECOG_COUNT);
   localparam logic [LOS_W-1:0] LOS_MAX   = LOS_W'(LOS_CYCLES);
   localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);

   state_t             state_r;
   state_t             state_nxt;
   logic [2:0]         rep_cnt;
   logic [2:0]         rep_nxt;
   logic [4:0]         last_prim;
   logic [4:0]         last_nxt;
   logic [LOS_W-1:0]   los_cnt;
   logic [LOS_W-1:0]   los_nxt;
   logic [TMR_W-1:0]   timer;
   logic [TMR_W-1:0]   tmr_nxt;
   logic               recog_hit;
   logic               rec_idle, rec_lr, rec_lrr, rec_nos, rec_ols;
   logic               los_fire;
   logic               timed;
   logic               tmr_fire;
   logic               lr_rise;

   function automatic logic [4:0] tx_of(input state_t s);
      case (s)
         ST_AC, ST_LR3:          tx_of = P_IDLE;
         ST_LR1, ST_OL2:         tx_of = P_LR;
         ST_LR2:                 tx_of = P_LRR;
         ST_LF1:                 tx_of = P_NOS;
         default:                tx_of = P_OLS;
      endcase
   endfunction

   // Recognition looks at the count including this cycle's word, so a
   // sequence completing on cycle N moves the state at the edge ending N.
   always_comb begin
      rep_nxt  = rep_cnt;
      last_nxt = last_prim;
      if (!rx_sync) begin
         rep_nxt = '0;
      end else if (rx_valid) begin
         if (rx_prim == last_prim) begin
            if (rep_cnt != RECOG_MAX) rep_nxt = rep_cnt + 3'd1;
         end else begin
            last_nxt = rx_prim;
            rep_nxt  = 3'd1;
         end
      end
   end

   assign recog_hit = (rep_nxt == RECOG_MAX);
   assign rec_idle  = recog_hit && (last_nxt == P_IDLE);
   assign rec_lr    = recog_hit && (last_nxt == P_LR);
   assign rec_lrr   = recog_hit && (last_nxt == P_LRR);
   assign rec_nos   = recog_hit && (last_nxt == P_NOS);
   assign rec_ols   = recog_hit && (last_nxt == P_OLS);

   always_comb begin
      los_nxt = los_cnt;
      if (rx_sync) los_nxt = '0;
      else if (los_cnt != LOS_MAX) los_nxt = los_cnt + LOS_W'(1);
   end

   assign los_fire = (los_nxt == LOS_MAX);

   assign timed = (state_r == ST_LR1) || (state_r == ST_LR2) || (state_r == ST_LR3) ||
                  (state_r == ST_OL2) || (state_r == ST_OL3);

   always_comb begin
      tmr_nxt = '0;
      if (timed) tmr_nxt = (timer == TMR_MAX) ? timer : timer + TMR_W'(1);
   end

   assign tmr_fire = timed && (tmr_nxt == TMR_MAX);

`ifdef FC_PORT_STATS_EN
   logic lr_req_q;
   assign lr_rise = lr_req && !lr_req_q;
`else
   assign lr_rise = 1'b0;
`endif

   always_comb begin
      state_nxt = state_r;
      if (offline_req) begin
         state_nxt = ST_OL1;
      end else if (los_fire && (state_r != ST_LF1) && (state_r != ST_OL1)) begin
         state_nxt = ST_LF1;
      end else if (tmr_fire) begin
         state_nxt = ST_LF1;
      end else begin
         case (state_r)
            ST_AC: begin
               if (lr_rise)      state_nxt = ST_LR1;
               else if (rec_lr)  state_nxt = ST_LR2;
               else if (rec_nos) state_nxt = ST_LF2;
               else if (rec_ols) state_nxt = ST_OL2;
            end
            ST_LR1: begin
               if (rec_lrr)      state_nxt = ST_LR3;
               else if (rec_lr)  state_nxt = ST_LR2;
               else if (rec_nos) state_nxt = ST_LF2;
            end
            ST_LR2: begin
               if (rec_idle)     state_nxt = ST_AC;
               else if (rec_lrr) state_nxt = ST_LR3;
               else if (rec_nos) state_nxt = ST_LF2;
            end
            ST_LR3: begin
               if (rec_idle)     state_nxt = ST_AC;
               else if (rec_lr)  state_nxt = ST_LR2;
               else if (rec_nos) state_nxt = ST_LF2;
            end
            ST_LF1: begin
               if (rec_nos)      state_nxt = ST_LF2;
               else if (rec_ols) state_nxt = ST_OL2;
            end
            ST_LF2: begin
               if (rec_ols)      state_nxt = ST_OL2;
               else if (rec_lr)  state_nxt = ST_LR2;
            end
            ST_OL1: begin
               if (rec_ols)      state_nxt = ST_OL2;
               else if (rec_lr)  state_nxt = ST_LR2;
               else if (rec_nos) state_nxt = ST_OL3;
            end
            ST_OL2: begin
               if (rec_lrr)      state_nxt = ST_LR3;
               else if (rec_lr)  state_nxt = ST_LR2;
               else if (rec_nos) state_nxt = ST_OL3;
            end
            ST_OL3: begin
               if (rec_ols)      state_nxt = ST_OL2;
               else if (rec_lr)  state_nxt = ST_LR2;
            end
            default:             state_nxt = ST_OL1;
         endcase
      end
   end

   // Any state change discards the partial sequence so one burst cannot cascade.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_OL1;
         tx_prim     <= P_OLS;
         link_active <= 1'b0;
         rep_cnt     <= '0;
         last_prim   <= '0;
         los_cnt     <= '0;
         timer       <= '0;
      end else begin
         state_r     <= state_nxt;
         tx_prim     <= tx_of(state_nxt);
         link_active <= (state_nxt == ST_AC);
         rep_cnt     <= (state_nxt != state_r) ? 3'd0 : rep_nxt;
         last_prim   <= last_nxt;
         los_cnt     <= los_nxt;
         timer       <= (state_nxt != state_r) ? '0 : tmr_nxt;
      end
   end

`ifdef FC_PORT_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lr_req_q        <= 1'b0;
         link_fail_count <= '0;
         lr_count        <= '0;
      end else begin
         lr_req_q <= lr_req;
         if ((state_nxt == ST_LF1) && (state_r != ST_LF1) && (link_fail_count != 16'hFFFF))
            link_fail_count <= link_fail_count + 16'd1;
         if ((state_nxt == ST_LR2) && (state_r != ST_LR2) && (lr_count != 16'hFFFF))
            lr_count <= lr_count + 16'd1;
      end
   end
`endif

   assign state = state_r;

endmodule

// File: tb/tb_fc_port_state_machine.sv
// tb/tb_fc_port_state_machine.sv - directed self-checking bench for fc_port_state_machine
module tb_fc_port_state_machine;

   localparam logic [4:0] P_IDLE = 5'd0;
   localparam logic [4:0] P_NOS  = 5'd14;
   localparam logic [4:0] P_OLS  = 5'd15;
   localparam logic [4:0] P_LR   = 5'd16;
   localparam logic [4:0] P_LRR  = 5'd17;
   localparam logic [4:0] P_UNK  = 5'd19;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [4:0]  rx_prim = 5'd0;
   logic        rx_sync = 1'b1;
   logic        offline_req = 1'b0;
   logic [3:0]  state;
   logic [4:0]  tx_prim;
   logic        link_active;
`ifdef FC_PORT_STATS_EN
   logic        lr_req = 1'b0;
   logic [15:0] link_fail_count;
   logic [15:0] lr_count;
`endif

   int checks = 0;
   int errors = 0;

   fc_port_state_machine #(
      .RECOG_COUNT    (3),
      .LOS_CYCLES     (1024),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .rx_valid        (rx_valid),
      .rx_prim         (rx_prim),
      .rx_sync         (rx_sync),
      .offline_req     (offline_req),
`ifdef FC_PORT_STATS_EN
      .lr_req          (lr_req),
      .link_fail_count (link_fail_count),
      .lr_count        (lr_count),
`endif
      .state           (state),
      .tx_prim         (tx_prim),
      .link_active     (link_active)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached state=%0d", state);
      $fatal(1, "watchdog");
   end

   task automatic send_word(input logic [4:0] p);
      rx_valid = 1'b1;
      rx_prim  = p;
      @(negedge clk);
   endtask

   task automatic send_seq(input logic [4:0] p, input int n);
      for (int i = 0; i < n; i++) send_word(p);
      rx_valid = 1'b0;
   endtask

   task automatic bring_up();
      send_seq(P_OLS, 3);
      send_seq(P_LRR, 3);
      send_seq(P_IDLE, 3);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (state !== 4'd6) begin errors++; $display("FAIL reset_state got=%0d exp=6", state); end
      checks++; if (tx_prim !== 5'd15) begin errors++; $display("FAIL reset_tx got=%0d exp=15", tx_prim); end
      checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL reset_link_active got=%0b exp=0", link_active); end
`ifdef FC_PORT_STATS_EN
      checks++; if (link_fail_count !== 16'd0 || lr_count !== 16'd0) begin errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", link_fail_count, lr_count); end
`endif
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_bringup();
      send_seq(P_OLS, 2);
      checks++; if (state !== 4'd6) begin errors++; $display("FAIL bringup_ols2 got=%0d exp=6", state); end
      send_seq(P_OLS, 1);
      checks++; if (state !== 4'd7 || tx_prim !== 5'd16) begin errors++; $display("FAIL bringup_ol2 got=%0d/%0d exp=7/16", state, tx_prim); end
      send_seq(P_LRR, 3);
      checks++; if (state !== 4'd3 || tx_prim !== 5'd0) begin errors++; $display("FAIL bringup_lr3 got=%0d/%0d exp=3/0", state, tx_prim); end
      send_seq(P_IDLE, 2);
      checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL bringup_idle2 link_active got=%0b exp=0", link_active); end
      send_seq(P_IDLE, 1);
      checks++; if (state !== 4'd0 || link_active !== 1'b1 || tx_prim !== 5'd0) begin errors++; $display("FAIL bringup_ac got=%0d/%0b/%0d exp=0/1/0", state, link_active, tx_prim); end
   endtask

   task automatic test_recog_reset();
      send_seq(P_UNK, 4);
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL data_in_ac got=%0d exp=0", state); end
      send_word(P_LR);
      send_word(P_LR);
      send_word(P_IDLE);
      send_word(P_LR);
      send_word(P_LR);
      rx_valid = 1'b0;
      @(negedge clk);
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL lr_broken got=%0d exp=0", state); end
      send_seq(P_LR, 1);
      checks++; if (state !== 4'd2 || tx_prim !== 5'd17) begin errors++; $display("FAIL lr_to_lr2 got=%0d/%0d exp=2/17", state, tx_prim); end
      send_seq(P_IDLE, 3);
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL lr2_to_ac got=%0d exp=0", state); end
   endtask

   task automatic test_los();
      rx_sync = 1'b0;
      repeat (1023) @(negedge clk);
      rx_sync = 1'b1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL los_1023_first got=%0d exp=0", state); end
      @(negedge clk);
      rx_sync = 1'b0;
      repeat (1023) @(negedge clk);
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL los_1023 got=%0d exp=0", state); end
      @(negedge clk);
      checks++; if (state !== 4'd4 || tx_prim !== 5'd14) begin errors++; $display("FAIL los_1024 got=%0d/%0d exp=4/14", state, tx_prim); end
      rx_sync = 1'b1;
      @(negedge clk);
      send_seq(P_NOS, 3);
      checks++; if (state !== 4'd5 || tx_prim !== 5'd15) begin errors++; $display("FAIL lf1_to_lf2 got=%0d/%0d exp=5/15", state, tx_prim); end
   endtask

   task automatic test_timeout();
      send_seq(P_OLS, 3);
      checks++; if (state !== 4'd7) begin errors++; $display("FAIL lf2_to_ol2 got=%0d exp=7", state); end
      repeat (49) @(negedge clk);
      checks++; if (state !== 4'd7) begin errors++; $display("FAIL timeout_early got=%0d exp=7", state); end
      @(negedge clk);
      checks++; if (state !== 4'd4 || tx_prim !== 5'd14) begin errors++; $display("FAIL timeout_lf1 got=%0d/%0d exp=4/14", state, tx_prim); end
   endtask

   task automatic test_offline();
      send_seq(P_NOS, 3);
      send_seq(P_LR, 3);
      send_seq(P_LRR, 3);
      checks++; if (state !== 4'd3) begin errors++; $display("FAIL reach_lr3 got=%0d exp=3", state); end
      offline_req = 1'b1;
      @(negedge clk);
      checks++; if (state !== 4'd6 || tx_prim !== 5'd15) begin errors++; $display("FAIL offline_ol1 got=%0d/%0d exp=6/15", state, tx_prim); end
      send_seq(P_LR, 3);
      checks++; if (state !== 4'd6) begin errors++; $display("FAIL offline_hold got=%0d exp=6", state); end
      offline_req = 1'b0;
      @(negedge clk);
      bring_up();
      checks++; if (state !== 4'd0 || link_active !== 1'b1) begin errors++; $display("FAIL offline_rebringup got=%0d/%0b exp=0/1", state, link_active); end
   endtask

   task automatic test_async_reset();
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (state !== 4'd6 || tx_prim !== 5'd15 || link_active !== 1'b0) begin errors++; $display("FAIL async_reset got=%0d/%0d/%0b exp=6/15/0", state, tx_prim, link_active); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      bring_up();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL post_reset_ac got=%0d exp=0", state); end
   endtask

`ifdef FC_PORT_STATS_EN
   task automatic force_los();
      rx_sync = 1'b0;
      repeat (1024) @(negedge clk);
      rx_sync = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_stats();
      lr_req = 1'b1;
      @(negedge clk);
      lr_req = 1'b0;
      checks++; if (state !== 4'd1 || tx_prim !== 5'd16) begin errors++; $display("FAIL lr_req_lr1 got=%0d/%0d exp=1/16", state, tx_prim); end
      send_seq(P_LRR, 3);
      checks++; if (state !== 4'd3) begin errors++; $display("FAIL lr1_to_lr3 got=%0d exp=3", state); end
      send_seq(P_IDLE, 3);
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL stats_ac got=%0d exp=0", state); end
      force_los();
      checks++; if (state !== 4'd4 || link_fail_count !== 16'd1) begin errors++; $display("FAIL stats_los1 got=%0d/%0d exp=4/1", state, link_fail_count); end
      send_seq(P_NOS, 3);
      force_los();
      checks++; if (state !== 4'd4 || link_fail_count !== 16'd2) begin errors++; $display("FAIL stats_los2 got=%0d/%0d exp=4/2", state, link_fail_count); end
      checks++; if (lr_count !== 16'd0) begin errors++; $display("FAIL stats_lr_count got=%0d exp=0", lr_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_bringup();
      test_recog_reset();
      test_los();
      test_timeout();
      test_offline();
      test_async_reset();
`ifdef FC_PORT_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
